// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, bit-serial shifts, and a
// valid/ready handshake that holds the result until the consumer takes it.
module multicycle_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       Func,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CarryIn,
    input  logic [SHW-1:0]   ShAmt,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam logic [3:0] F_NOP = 4'd0;
    localparam logic [3:0] F_ACC = 4'd1;
    localparam logic [3:0] F_ADC = 4'd2;
    localparam logic [3:0] F_MEM = 4'd3;
    localparam logic [3:0] F_ADD = 4'd4;
    localparam logic [3:0] F_SUB = 4'd5;
    localparam logic [3:0] F_AND = 4'd6;
    localparam logic [3:0] F_OR  = 4'd7;
    localparam logic [3:0] F_NOT = 4'd8;
    localparam logic [3:0] F_LSL = 4'd9;
    localparam logic [3:0] F_LSR = 4'd10;
    localparam logic [3:0] F_ASR = 4'd11;
    localparam logic [3:0] F_XOR = 4'd12;
    localparam logic [3:0] F_SUC = 4'd13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [WIDTH:0] add_ext(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    endfunction

    function automatic logic signed_ovf(input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y,
                                        input logic [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic is_shift(input logic [3:0] f);
        return (f == F_LSL) || (f == F_LSR) || (f == F_ASR);
    endfunction

    state_t             state_r, state_nx_s;
    logic [3:0]         func_r, func_nx_s;
    logic [WIDTH-1:0]   shreg_r, shreg_nx_s;
    logic [SHW-1:0]     cnt_r, cnt_nx_s;
    logic [WIDTH-1:0]   result_r, result_nx_s;
    logic               z_r, n_r, c_r, v_r;
    logic               z_nx_s, n_nx_s, c_nx_s, v_nx_s;
    logic               valid_r, ready_r;

    logic [WIDTH-1:0]   b_op_s;
    logic               ci_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   imm_res_s;
    logic               imm_c_s, imm_v_s, imm_flag_en_s;
    logic [WIDTH-1:0]   step_val_s;
    logic               step_out_s;

    // Operand conditioning: subtraction is A + ~B + carry
    always_comb begin
        b_op_s = B;
        ci_s   = 1'b0;
        case (Func)
            F_ADC: begin
                b_op_s = B;
                ci_s   = CarryIn;
            end
            F_SUB: begin
                b_op_s = ~B;
                ci_s   = 1'b1;
            end
            F_SUC: begin
                b_op_s = ~B;
                ci_s   = CarryIn;
            end
            default: begin
                b_op_s = B;
                ci_s   = 1'b0;
            end
        endcase
    end

    assign sum_s = add_ext(A, b_op_s, ci_s);

    // Single-cycle result for everything except shifts with a nonzero distance
    always_comb begin
        imm_res_s     = A;
        imm_c_s       = 1'b0;
        imm_v_s       = 1'b0;
        imm_flag_en_s = 1'b1;
        case (Func)
            F_NOP: imm_flag_en_s = 1'b0;
            F_ACC: imm_res_s = A;
            F_MEM: imm_res_s = B;
            F_ADD, F_ADC, F_SUB, F_SUC: begin
                imm_res_s = sum_s[WIDTH-1:0];
                imm_c_s   = sum_s[WIDTH];
                imm_v_s   = signed_ovf(A, b_op_s, sum_s[WIDTH-1:0]);
            end
            F_AND: imm_res_s = A & B;
            F_OR:  imm_res_s = A | B;
            F_XOR: imm_res_s = A ^ B;
            F_NOT: imm_res_s = ~A;
            F_LSL, F_LSR, F_ASR: imm_res_s = A;
            default: imm_flag_en_s = 1'b0;
        endcase
    end

    // One-bit shift step on the working register
    always_comb begin
        step_val_s = shreg_r;
        step_out_s = 1'b0;
        case (func_r)
            F_LSL: begin
                step_val_s = {shreg_r[WIDTH-2:0], 1'b0};
                step_out_s = shreg_r[WIDTH-1];
            end
            F_LSR: begin
                step_val_s = {1'b0, shreg_r[WIDTH-1:1]};
                step_out_s = shreg_r[0];
            end
            F_ASR: begin
                step_val_s = {shreg_r[WIDTH-1], shreg_r[WIDTH-1:1]};
                step_out_s = shreg_r[0];
            end
            default: begin
                step_val_s = shreg_r;
                step_out_s = 1'b0;
            end
        endcase
    end

    // Next-state and datapath load control
    always_comb begin
        state_nx_s  = state_r;
        func_nx_s   = func_r;
        shreg_nx_s  = shreg_r;
        cnt_nx_s    = cnt_r;
        result_nx_s = result_r;
        z_nx_s      = z_r;
        n_nx_s      = n_r;
        c_nx_s      = c_r;
        v_nx_s      = v_r;
        case (state_r)
            IDLE: begin
                if (InValid) begin
                    func_nx_s = Func;
                    if (is_shift(Func) && (ShAmt != {SHW{1'b0}})) begin
                        state_nx_s = SHIFT;
                        shreg_nx_s = A;
                        cnt_nx_s   = ShAmt;
                    end else begin
                        state_nx_s  = DONE;
                        result_nx_s = imm_res_s;
                        z_nx_s      = imm_flag_en_s && (imm_res_s == {WIDTH{1'b0}});
                        n_nx_s      = imm_flag_en_s && imm_res_s[WIDTH-1];
                        c_nx_s      = imm_flag_en_s && imm_c_s;
                        v_nx_s      = imm_flag_en_s && imm_v_s;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                shreg_nx_s = step_val_s;
                cnt_nx_s   = cnt_r - SHW'(1);
                if (cnt_r == SHW'(1)) begin
                    state_nx_s  = DONE;
                    result_nx_s = step_val_s;
                    z_nx_s      = (step_val_s == {WIDTH{1'b0}});
                    n_nx_s      = step_val_s[WIDTH-1];
                    c_nx_s      = step_out_s;
                    v_nx_s      = 1'b0;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State and output registers; reset wins over any simultaneous request
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r  <= IDLE;
            func_r   <= 4'd0;
            shreg_r  <= {WIDTH{1'b0}};
            cnt_r    <= {SHW{1'b0}};
            result_r <= {WIDTH{1'b0}};
            z_r      <= 1'b0;
            n_r      <= 1'b0;
            c_r      <= 1'b0;
            v_r      <= 1'b0;
            valid_r  <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            state_r  <= state_nx_s;
            func_r   <= func_nx_s;
            shreg_r  <= shreg_nx_s;
            cnt_r    <= cnt_nx_s;
            result_r <= result_nx_s;
            z_r      <= z_nx_s;
            n_r      <= n_nx_s;
            c_r      <= c_nx_s;
            v_r      <= v_nx_s;
            valid_r  <= (state_nx_s == DONE);
            ready_r  <= (state_nx_s == IDLE);
        end
    end

    assign InReady  = ready_r;
    assign OutValid = valid_r;
    assign Result   = result_r;
    assign Z        = z_r;
    assign N        = n_r;
    assign C        = c_r;
    assign V        = v_r;

endmodule

// File: tb/tb_multicycle_alu.sv
// Testbench for multicycle_alu (WIDTH=16): directed vector table, reset and
// handshake corner cases, and random ops against an arithmetic reference model.
module tb_multicycle_alu;

    logic        Clock = 1'b0;
    logic        Reset, InValid, InReady, CarryIn, OutValid, OutReady;
    logic [3:0]  Func;
    logic [15:0] A, B, Result;
    logic [3:0]  ShAmt;
    logic        Z, N, C, V;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [3:0]  k;
        logic [15:0] r;
        logic [3:0]  flags;  // {Z,N,C,V}
        int          lat;
    } vec_t;

    vec_t tbl[$];

    multicycle_alu #(.WIDTH(16)) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .Func(Func), .A(A), .B(B), .CarryIn(CarryIn), .ShAmt(ShAmt),
        .OutValid(OutValid), .OutReady(OutReady), .Result(Result),
        .Z(Z), .N(N), .C(C), .V(V)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic straight from the op definitions
    function automatic vec_t model(input logic [3:0] f, input logic [15:0] a,
                                   input logic [15:0] b, input logic ci, input logic [3:0] k);
        vec_t e;
        int ua, ub, sa, sb, full, ideal, kk;
        logic [15:0] r;
        logic c, v, z, n;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        kk = int'(k);
        r = a; c = 1'b0; v = 1'b0; full = 0; ideal = 0;
        e.lat = 1;
        case (f)
            4'd2, 4'd4, 4'd5, 4'd13: begin
                if (f == 4'd4) begin full = ua + ub; ideal = sa + sb; end
                else if (f == 4'd2) begin full = ua + ub + int'(ci); ideal = sa + sb + int'(ci); end
                else if (f == 4'd5) begin full = ua + (65535 - ub) + 1; ideal = sa - sb; end
                else begin full = ua + (65535 - ub) + int'(ci); ideal = sa - sb - 1 + int'(ci); end
                r = full[15:0];
                c = (full >= 65536);
                v = (ideal > 32767) || (ideal < -32768);
            end
            4'd3:  r = b;
            4'd6:  r = a & b;
            4'd7:  r = a | b;
            4'd8:  r = ~a;
            4'd12: r = a ^ b;
            4'd9: begin
                full = ua << kk;
                r = full[15:0];
                c = (kk > 0) ? a[16 - kk] : 1'b0;
                e.lat = kk + 1;
            end
            4'd10: begin
                r = a >> kk;
                c = (kk > 0) ? a[kk - 1] : 1'b0;
                e.lat = kk + 1;
            end
            4'd11: begin
                full = sa >>> kk;
                r = full[15:0];
                c = (kk > 0) ? a[kk - 1] : 1'b0;
                e.lat = kk + 1;
            end
            default: r = a;
        endcase
        z = (r == 16'h0000);
        n = r[15];
        if (f == 4'd0 || f >= 4'd14) begin
            z = 1'b0; n = 1'b0; c = 1'b0; v = 1'b0;
        end
        e.f = f; e.a = a; e.b = b; e.ci = ci; e.k = k;
        e.r = r; e.flags = {z, n, c, v};
        return e;
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_outvalid"}, OutValid, 1'b0);
        chk({tag, "_result"}, Result, 16'h0000);
        chk({tag, "_flags"}, {Z, N, C, V}, 4'b0000);
        chk({tag, "_inready"}, InReady, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Issue one op, measure latency, check result, hold in DONE, then release
    task automatic do_op(input vec_t v, input int hold, input string tag);
        int cyc;
        logic busy_ok;
        logic [20:0] snap;
        busy_ok = 1'b1;
        @(negedge Clock);
        chk({tag, "_ready_pre"}, InReady, 1'b1);
        InValid = 1'b1; Func = v.f; A = v.a; B = v.b; CarryIn = v.ci; ShAmt = v.k;
        @(negedge Clock);
        cyc = 1;
        while (!OutValid && cyc < 40) begin
            if (InReady) busy_ok = 1'b0;
            InValid = 1'($urandom); Func = 4'($urandom); A = 16'($urandom);
            B = 16'($urandom); CarryIn = 1'($urandom); ShAmt = 4'($urandom);
            @(negedge Clock);
            cyc++;
        end
        if (InReady) busy_ok = 1'b0;
        chk({tag, "_latency"}, cyc, v.lat);
        chk({tag, "_result"}, Result, v.r);
        chk({tag, "_flags"}, {Z, N, C, V}, v.flags);
        chk({tag, "_busy_noready"}, busy_ok, 1'b1);
        if (cyc >= 40) begin
            do_reset();
        end else begin
            snap = {OutValid, Result, Z, N, C, V};
            for (int i = 0; i < hold; i++) begin
                OutReady = 1'b0; InValid = 1'b1; A = 16'($urandom); B = 16'($urandom);
                @(negedge Clock);
                chk({tag, "_hold"}, {OutValid, Result, Z, N, C, V}, snap);
                chk({tag, "_hold_noready"}, InReady, 1'b0);
            end
            OutReady = 1'b1; InValid = 1'b0;
            @(negedge Clock);
            OutReady = 1'b0;
            chk({tag, "_release_valid"}, OutValid, 1'b0);
            chk({tag, "_release_ready"}, InReady, 1'b1);
        end
    endtask

    initial begin
        vec_t v;
        Reset = 1'b0; InValid = 1'b0; OutReady = 1'b0; Func = 4'd0;
        A = 16'h0; B = 16'h0; CarryIn = 1'b0; ShAmt = 4'd0;

        // {f, a, b, ci, k, result, {Z,N,C,V}, latency}
        tbl.push_back('{4'd4,  16'h7FFF, 16'h0001, 1'b0, 4'd0,  16'h8000, 4'b0101, 1});
        tbl.push_back('{4'd2,  16'hFFFF, 16'h0000, 1'b1, 4'd0,  16'h0000, 4'b1010, 1});
        tbl.push_back('{4'd5,  16'h0005, 16'h0005, 1'b0, 4'd0,  16'h0000, 4'b1010, 1});
        tbl.push_back('{4'd11, 16'h8010, 16'h0000, 1'b0, 4'd4,  16'hF801, 4'b0100, 5});
        tbl.push_back('{4'd9,  16'h8001, 16'h0000, 1'b0, 4'd1,  16'h0002, 4'b0010, 2});
        tbl.push_back('{4'd14, 16'h1234, 16'h0000, 1'b0, 4'd0,  16'h1234, 4'b0000, 1});
        tbl.push_back('{4'd3,  16'h1111, 16'hABCD, 1'b0, 4'd0,  16'hABCD, 4'b0100, 1});
        tbl.push_back('{4'd8,  16'hFFFF, 16'h0000, 1'b0, 4'd0,  16'h0000, 4'b1000, 1});
        tbl.push_back('{4'd5,  16'h0000, 16'h0001, 1'b0, 4'd0,  16'hFFFF, 4'b0100, 1});
        tbl.push_back('{4'd5,  16'h8000, 16'h0001, 1'b0, 4'd0,  16'h7FFF, 4'b0011, 1});
        tbl.push_back('{4'd9,  16'h0001, 16'h0000, 1'b0, 4'd15, 16'h8000, 4'b0100, 16});
        tbl.push_back('{4'd10, 16'h8000, 16'h0000, 1'b0, 4'd0,  16'h8000, 4'b0100, 1});
        tbl.push_back('{4'd13, 16'h0005, 16'h0003, 1'b0, 4'd0,  16'h0001, 4'b0010, 1});
        tbl.push_back('{4'd12, 16'hF0F0, 16'hFF00, 1'b0, 4'd0,  16'h0FF0, 4'b0000, 1});
        tbl.push_back('{4'd0,  16'h0000, 16'h5555, 1'b0, 4'd0,  16'h0000, 4'b0000, 1});
        tbl.push_back('{4'd1,  16'h8000, 16'h0000, 1'b0, 4'd0,  16'h8000, 4'b0100, 1});
        tbl.push_back('{4'd10, 16'hFFFF, 16'h0000, 1'b0, 4'd15, 16'h0001, 4'b0010, 16});
        tbl.push_back('{4'd11, 16'h7FFF, 16'h0000, 1'b0, 4'd15, 16'h0000, 4'b1010, 16});

        do_reset();
        check_reset_state("reset");

        foreach (tbl[i]) do_op(tbl[i], (i == 0) ? 3 : int'(i % 2), $sformatf("vec%0d", i));

        // Reset in the 2nd SHIFT cycle of LSR by 8 aborts without OutValid
        v = model(4'd4, 16'h1234, 16'h1111, 1'b0, 4'd0);
        do_op(v, 0, "pre_abort");
        @(negedge Clock);
        InValid = 1'b1; Func = 4'd10; A = 16'hF0F0; ShAmt = 4'd8;
        @(negedge Clock);
        InValid = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check_reset_state("abort_shift");
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge Clock);
                if (OutValid) seen = 1'b1;
            end
            chk("abort_shift_no_valid", seen, 1'b0);
        end

        // Reset while DONE is waiting on OutReady
        @(negedge Clock);
        InValid = 1'b1; Func = 4'd7; A = 16'h00F0; B = 16'h0F00;
        @(negedge Clock);
        InValid = 1'b0;
        chk("done_pre_valid", OutValid, 1'b1);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check_reset_state("abort_done");

        // Reset takes priority over a request on the same edge
        @(negedge Clock);
        InValid = 1'b1; Reset = 1'b1; Func = 4'd4; A = 16'h0001; B = 16'h0001;
        @(negedge Clock);
        InValid = 1'b0; Reset = 1'b0;
        check_reset_state("rst_vs_accept");
        @(negedge Clock);
        chk("rst_vs_accept_later", OutValid, 1'b0);

        for (int i = 0; i < 150; i++) begin
            v = model(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                      1'($urandom), 4'($urandom));
            do_op(v, $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
